// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN classifier-head blocks.
package cnn_pkg;

  localparam int unsigned CNN_ACC_WIDTH   = 24;
  localparam int unsigned CNN_NUM_CLASSES = 10;

  // Most-negative score at the default accumulator width.
  localparam logic [CNN_ACC_WIDTH-1:0] CNN_SCORE_MIN = {1'b1, {(CNN_ACC_WIDTH-1){1'b0}}};

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } fc_argmax_state_t;

endpackage

// File: rtl/fc_argmax_if.sv
// Score-in / result-out handshake bundle of the argmax classifier head.
interface fc_argmax_if #(
  parameter int unsigned ACC_WIDTH   = 24,
  parameter int unsigned NUM_CLASSES = 10
);
  localparam int unsigned IDX_WIDTH = $clog2(NUM_CLASSES);

  logic                        in_valid;
  logic signed [ACC_WIDTH-1:0] in_data;
  logic [IDX_WIDTH-1:0]        in_idx;
  logic                        in_ready;
  logic                        class_valid;
  logic                        class_ready;
  logic [IDX_WIDTH-1:0]        class_idx;
  logic signed [ACC_WIDTH-1:0] class_score;
  logic [ACC_WIDTH:0]          class_margin;

  modport slave (
    input  in_valid, in_data, in_idx, class_ready,
    output in_ready, class_valid, class_idx, class_score, class_margin
  );

  modport master (
    output in_valid, in_data, in_idx, class_ready,
    input  in_ready, class_valid, class_idx, class_score, class_margin
  );
endinterface

// File: rtl/top2_update.sv
// Combinational best/second-best tracker step; strict compares keep the lowest index on ties.
module top2_update #(
  parameter int unsigned W  = 24,
  parameter int unsigned IW = 4
) (
  input  logic signed [W-1:0] best,
  input  logic signed [W-1:0] second,
  input  logic [IW-1:0]       best_idx,
  input  logic signed [W-1:0] in_data,
  input  logic [IW-1:0]       in_idx,
  input  logic                first,
  output logic signed [W-1:0] best_nxt,
  output logic signed [W-1:0] second_nxt,
  output logic [IW-1:0]       best_idx_nxt
);
  localparam logic signed [W-1:0] SCORE_MIN = {1'b1, {(W-1){1'b0}}};

  // Fold one score into the running top-2.
  always_comb begin
    best_nxt     = best;
    second_nxt   = second;
    best_idx_nxt = best_idx;
    if (first) begin
      best_nxt     = in_data;
      best_idx_nxt = '0;
      second_nxt   = SCORE_MIN;
    end else if (in_data > best) begin
      second_nxt   = best;
      best_nxt     = in_data;
      best_idx_nxt = in_idx;
    end else if (in_data > second) begin
      second_nxt   = in_data;
    end
  end
endmodule

// File: rtl/fc_argmax.sv
// Classifier head: tracks top-2 scores over a frame and presents the argmax result.
module fc_argmax
  import cnn_pkg::*;
#(
  parameter int unsigned ACC_WIDTH   = CNN_ACC_WIDTH,
  parameter int unsigned NUM_CLASSES = CNN_NUM_CLASSES,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  fc_argmax_if.slave           bus,
  output logic                 seq_err,
  output logic [CNT_WIDTH-1:0] frame_count
);
  localparam int unsigned IDX_W = $clog2(NUM_CLASSES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  fc_argmax_state_t              state_q, state_d;
  logic [IDX_W-1:0]              expect_q, expect_d;
  logic [IDX_W-1:0]              last_idx_q, last_idx_d;
  logic                          last_vld_q, last_vld_d;
  logic signed [ACC_WIDTH-1:0]   best_q, best_d, second_q, second_d;
  logic [IDX_W-1:0]              best_idx_q, best_idx_d;
  logic                          in_ready_q, in_ready_d;
  logic                          class_valid_q, class_valid_d;
  logic [IDX_W-1:0]              class_idx_q, class_idx_d;
  logic signed [ACC_WIDTH-1:0]   class_score_q, class_score_d;
  logic [ACC_WIDTH:0]            class_margin_q, class_margin_d;
  logic                          seq_err_q, seq_err_d;
  logic [CNT_WIDTH-1:0]          frame_count_q, frame_count_d;

  logic                          collecting, idx_match, accept, dup, restart, bad;
  logic                          take, first, done, handshake;
  logic signed [ACC_WIDTH-1:0]   best_n, second_n;
  logic [IDX_W-1:0]              best_idx_n;

  // Index check: accept in order, silently drop a repeat of the last accepted
  // index, restart on an early index 0, otherwise flag and drop.
  always_comb begin
    collecting = (state_q == COLLECT);
    idx_match  = (bus.in_idx == expect_q);
    accept     = collecting & bus.in_valid & idx_match;
    dup        = collecting & bus.in_valid & ~idx_match & last_vld_q & (bus.in_idx == last_idx_q);
    restart    = collecting & bus.in_valid & ~idx_match & ~dup & (bus.in_idx == '0);
    bad        = collecting & bus.in_valid & ~idx_match & ~dup & ~restart;
    take       = accept | restart;
    first      = (bus.in_idx == '0);
    done       = take & (bus.in_idx == LAST_IDX);
    handshake  = class_valid_q & bus.class_ready;
  end

  top2_update #(.W(ACC_WIDTH), .IW(IDX_W)) u_top2 (
    .best         (best_q),
    .second       (second_q),
    .best_idx     (best_idx_q),
    .in_data      (bus.in_data),
    .in_idx       (bus.in_idx),
    .first        (first),
    .best_nxt     (best_n),
    .second_nxt   (second_n),
    .best_idx_nxt (best_idx_n)
  );

  // Next-state for sequencing, result capture, error flag and counter; clear overrides all.
  always_comb begin
    state_d        = state_q;
    expect_d       = expect_q;
    last_idx_d     = last_idx_q;
    last_vld_d     = last_vld_q;
    best_d         = best_q;
    second_d       = second_q;
    best_idx_d     = best_idx_q;
    in_ready_d     = in_ready_q;
    class_valid_d  = class_valid_q;
    class_idx_d    = class_idx_q;
    class_score_d  = class_score_q;
    class_margin_d = class_margin_q;
    seq_err_d      = seq_err_q | restart | bad;
    frame_count_d  = frame_count_q;

    if (take) begin
      best_d     = best_n;
      second_d   = second_n;
      best_idx_d = best_idx_n;
      expect_d   = bus.in_idx + IDX_W'(1);
      last_idx_d = bus.in_idx;
      last_vld_d = 1'b1;
    end
    if (done) begin
      state_d        = HOLD;
      in_ready_d     = 1'b0;
      class_valid_d  = 1'b1;
      class_idx_d    = best_idx_n;
      class_score_d  = best_n;
      class_margin_d = {best_n[ACC_WIDTH-1], best_n} - {second_n[ACC_WIDTH-1], second_n};
    end
    if (handshake) begin
      state_d       = COLLECT;
      expect_d      = '0;
      in_ready_d    = 1'b1;
      class_valid_d = 1'b0;
      frame_count_d = frame_count_q + CNT_WIDTH'(1);
    end
    if (clear) begin
      state_d        = COLLECT;
      expect_d       = '0;
      last_idx_d     = '0;
      last_vld_d     = 1'b0;
      best_d         = '0;
      second_d       = '0;
      best_idx_d     = '0;
      in_ready_d     = 1'b1;
      class_valid_d  = 1'b0;
      class_idx_d    = '0;
      class_score_d  = '0;
      class_margin_d = '0;
      seq_err_d      = 1'b0;
      frame_count_d  = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= COLLECT;
      expect_q       <= '0;
      last_idx_q     <= '0;
      last_vld_q     <= 1'b0;
      best_q         <= '0;
      second_q       <= '0;
      best_idx_q     <= '0;
      in_ready_q     <= 1'b1;
      class_valid_q  <= 1'b0;
      class_idx_q    <= '0;
      class_score_q  <= '0;
      class_margin_q <= '0;
      seq_err_q      <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      expect_q       <= expect_d;
      last_idx_q     <= last_idx_d;
      last_vld_q     <= last_vld_d;
      best_q         <= best_d;
      second_q       <= second_d;
      best_idx_q     <= best_idx_d;
      in_ready_q     <= in_ready_d;
      class_valid_q  <= class_valid_d;
      class_idx_q    <= class_idx_d;
      class_score_q  <= class_score_d;
      class_margin_q <= class_margin_d;
      seq_err_q      <= seq_err_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.class_valid  = class_valid_q;
  assign bus.class_idx    = class_idx_q;
  assign bus.class_score  = class_score_q;
  assign bus.class_margin = class_margin_q;
  assign seq_err          = seq_err_q;
  assign frame_count      = frame_count_q;
endmodule

// File: tb/tb_fc_argmax.sv
// Bench for fc_argmax: frame-level reference model compared every cycle, plus literal result checks.
module tb_fc_argmax;
  localparam int N    = 10;
  localparam int SMIN = -8388608;
  localparam int SMAX = 8388607;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        seq_err;
  logic [15:0] frame_count;

  fc_argmax_if #(.ACC_WIDTH(24), .NUM_CLASSES(N)) bus ();

  fc_argmax #(.ACC_WIDTH(24), .NUM_CLASSES(N), .CNT_WIDTH(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .bus         (bus),
    .seq_err     (seq_err),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int     m_scores[N];
  bit     m_hold;
  int     m_expect;
  int     m_last;
  bit     m_in_ready, m_cv, m_seq;
  int     m_cidx;
  longint m_cscore, m_cmargin;
  int     m_fc;

  task automatic m_reset();
    m_hold = 0; m_expect = 0; m_last = -1;
    m_in_ready = 1; m_cv = 0; m_seq = 0;
    m_cidx = 0; m_cscore = 0; m_cmargin = 0; m_fc = 0;
  endtask

  // Argmax = first index holding the maximum; margin = max minus the largest
  // remaining value of the frame (a duplicate max yields 0).
  task automatic m_result();
    int bi = 0;
    bit have = 0;
    longint sec = 0;
    for (int i = 1; i < N; i++) if (m_scores[i] > m_scores[bi]) bi = i;
    for (int i = 0; i < N; i++)
      if (i != bi && (!have || m_scores[i] > sec)) begin sec = m_scores[i]; have = 1; end
    m_cidx   = bi;
    m_cscore = m_scores[bi];
    m_cmargin = longint'(m_scores[bi]) - sec;
  endtask

  task automatic m_accept(input int idx, input int d);
    m_scores[idx] = d;
    m_last = idx;
    m_expect = idx + 1;
    if (idx == N - 1) begin
      m_result();
      m_hold = 1; m_cv = 1; m_in_ready = 0;
    end
  endtask

  task automatic m_step();
    int idx;
    int d;
    idx = int'(bus.in_idx);
    d   = int'(bus.in_data);
    if (!m_hold) begin
      if (bus.in_valid) begin
        if (idx == m_expect) m_accept(idx, d);
        else if (idx == m_last) ;
        else if (idx == 0) begin m_accept(0, d); m_seq = 1; end
        else m_seq = 1;
      end
    end else if (bus.class_ready) begin
      m_hold = 0; m_cv = 0; m_in_ready = 1; m_expect = 0;
      m_fc = (m_fc + 1) % 65536;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n || clear) m_reset();
      else m_step();
    end
  end

  // Compare DUT against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        check("in_ready",     bus.in_ready,              m_in_ready);
        check("class_valid",  bus.class_valid,           m_cv);
        check("class_idx",    longint'(bus.class_idx),   m_cidx);
        check("class_score",  longint'(bus.class_score), m_cscore);
        check("class_margin", longint'(bus.class_margin), m_cmargin);
        check("seq_err",      seq_err,                   m_seq);
        check("frame_count",  longint'(frame_count),     m_fc);
      end
    end
  end

  // ---------------- stimulus ----------------
  int frame[N];

  task automatic send(input int idx, input int d);
    bus.in_valid = 1'b1;
    bus.in_idx   = idx[3:0];
    bus.in_data  = d[23:0];
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame();
    for (int i = 0; i < N; i++) send(i, frame[i]);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.class_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("class_valid_wait", bus.class_valid, 1);
  endtask

  task automatic expect_result(input int idx, input longint score, input longint margin);
    wait_valid();
    check("lit_class_idx",    longint'(bus.class_idx),    idx);
    check("lit_class_score",  longint'(bus.class_score),  score);
    check("lit_class_margin", longint'(bus.class_margin), margin);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n         = 1'b1;
    clear           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_idx      = '0;
    bus.in_data     = '0;
    bus.class_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("rst_in_ready",    bus.in_ready, 1);
    check("rst_class_valid", bus.class_valid, 0);
    check("rst_seq_err",     seq_err, 0);
    check("rst_frame_count", longint'(frame_count), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    checking = 1'b1;
    @(posedge clk);
    #1;

    // Tie on 17: lowest index wins.
    frame = '{5, -3, 17, 2, 17, 0, -8, 9, 1, 4};
    send_frame();
    expect_result(2, 17, 0);
    check("lit_fc_1",       longint'(frame_count), 1);
    check("lit_ready_after", bus.in_ready, 1);

    // All scores at the most-negative value.
    for (int i = 0; i < N; i++) frame[i] = SMIN;
    send_frame();
    expect_result(0, SMIN, 0);
    check("lit_seq_err_0", seq_err, 0);

    // Held index 3, then out-of-order index 6 while expecting 5.
    send(0, 10); send(1, 20); send(2, 30);
    for (int i = 0; i < 4; i++) send(3, 40);
    send(4, -5);
    check("lit_hold_no_err", seq_err, 0);
    send(6, 1000);
    check("lit_skip_err", seq_err, 1);
    send(5, 7); send(6, 3); send(7, 41); send(8, 0); send(9, 2);
    bus.in_valid = 1'b0;
    expect_result(7, 41, 1);

    // Clear, then an early index 0 restarts the frame.
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    check("lit_clear_seq", seq_err, 0);
    for (int i = 0; i < 7; i++) send(i, 100 * (i + 1));
    send(0, -1);
    check("lit_restart_err", seq_err, 1);
    for (int i = 1; i < N; i++) send(i, -(i + 1));
    bus.in_valid = 1'b0;
    expect_result(0, -1, 1);

    // Consumer stalls for 5 cycles while scores keep arriving.
    bus.class_ready = 1'b0;
    for (int i = 0; i < N; i++) frame[i] = 3 * i;
    send_frame();
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      send(0, 999);
      check("lit_stall_valid", bus.class_valid, 1);
      check("lit_stall_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    check("lit_stall_idx",    longint'(bus.class_idx), 9);
    check("lit_stall_margin", longint'(bus.class_margin), 3);
    bus.class_ready = 1'b1;
    @(posedge clk);
    #1;
    check("lit_hs_valid", bus.class_valid, 0);
    check("lit_hs_ready", bus.in_ready, 1);
    check("lit_fc_2",     longint'(frame_count), 2);

    // Full-range margin, then clear colliding with the handshake.
    bus.class_ready = 1'b0;
    for (int i = 0; i < N; i++) frame[i] = SMIN;
    frame[7] = SMAX;
    send_frame();
    expect_result(7, SMAX, 64'd16777215);
    bus.class_ready = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    check("lit_clear_fc",     longint'(frame_count), 0);
    check("lit_clear_valid",  bus.class_valid, 0);
    check("lit_clear_margin", longint'(bus.class_margin), 0);

    // Asynchronous reset while expecting index 4.
    frame = '{-100, 50, 49, -2, 50, 0, 1, 2, 3, 4};
    send_frame();
    expect_result(1, 50, 0);
    for (int i = 0; i < 4; i++) send(i, 7 * i);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("lit_arst_ready", bus.in_ready, 1);
    check("lit_arst_fc",    longint'(frame_count), 0);
    check("lit_arst_score", longint'(bus.class_score), 0);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    frame = '{1, 2, 3, 4, 5, 6, 7, 8, 9, -9};
    send_frame();
    expect_result(8, 9, 1);
    check("lit_fc_after_rst", longint'(frame_count), 1);

    repeat (3) @(posedge clk);
    #1 checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
